// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
//    Two-port arbiter and sequencer in front of the single-port statistics RAM.
//    Port 0 (CPU data master) issues reads and writes. Port 1 (stats engine)
//    issues reads, writes and atomic read-modify-write increments. One RAM
//    access per cycle, round-robin fairness between the ports.
//
// Ports
//    clk, reset             single clock, synchronous active-high reset
//    s0_*                   port 0 Avalon slave (address, byteenable, read,
//                           write, writedata, waitrequest, readdata, readdatavalid)
//    s1_*                   port 1 Avalon slave plus s1_incr (addend on writedata)
//    sat_event              one-cycle pulse when an increment clamps
//    mem_*                  RAM Avalon master pins (q arrives one cycle after read)
module onchip_mem_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter bit SATURATE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     s0_address,
   input  logic [DATA_W/8-1:0]   s0_byteenable,
   input  logic                  s0_read,
   input  logic                  s0_write,
   input  logic [DATA_W-1:0]     s0_writedata,
   output logic                  s0_waitrequest,
   output logic [DATA_W-1:0]     s0_readdata,
   output logic                  s0_readdatavalid,
   input  logic [ADDR_W-1:0]     s1_address,
   input  logic                  s1_read,
   input  logic                  s1_write,
   input  logic                  s1_incr,
   input  logic [DATA_W-1:0]     s1_writedata,
   output logic                  s1_waitrequest,
   output logic [DATA_W-1:0]     s1_readdata,
   output logic                  s1_readdatavalid,
   output logic                  sat_event,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_INCR_WB = 1'b1
   } state_t;

   // Increment sum kept one bit wider so the carry flags overflow.
   function automatic logic [DATA_W:0] incr_sum(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   state_t              state_r;
   logic                last_r;        // 1'b1: port 1 was granted most recently
   logic                rdv0_r;
   logic                rdv1_r;
   logic                sat_r;
   logic [ADDR_W-1:0]   incr_addr_r;
   logic [DATA_W-1:0]   incr_add_r;

   logic                idle_s;
   logic                req0_s;
   logic                req1_s;
   logic                grant0_s;
   logic                grant1_s;
   logic                wb_s;
   logic [DATA_W:0]     sum_s;
   logic                ovf_s;
   logic [DATA_W-1:0]   wb_data_s;

   // Grant decode: only in IDLE and out of reset; ties go to the port not served last.
   assign idle_s   = (state_r == ST_IDLE) && !reset;
   assign req0_s   = s0_read || s0_write;
   assign req1_s   = s1_read || s1_write || s1_incr;
   assign grant0_s = idle_s && req0_s && (!req1_s || last_r);
   assign grant1_s = idle_s && req1_s && (!req0_s || !last_r);
   assign wb_s     = (state_r == ST_INCR_WB) && !reset;

   assign sum_s     = incr_sum(mem_readdata, incr_add_r);
   assign ovf_s     = sum_s[DATA_W];
   assign wb_data_s = (ovf_s && SATURATE) ? {DATA_W{1'b1}} : sum_s[DATA_W-1:0];

   assign s0_waitrequest   = !grant0_s;
   assign s1_waitrequest   = !grant1_s;
   assign s0_readdata      = mem_readdata;
   assign s1_readdata      = mem_readdata;
   assign s0_readdatavalid = rdv0_r;
   assign s1_readdatavalid = rdv1_r;
   assign sat_event        = sat_r;
   assign mem_clken        = 1'b1;

   // RAM command mux: granted port in IDLE, write-back in INCR_WB, otherwise quiet.
   always_comb begin
      mem_address    = {ADDR_W{1'b0}};
      mem_byteenable = {BE_W{1'b1}};
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_writedata  = {DATA_W{1'b0}};
      if (grant0_s) begin
         mem_address    = s0_address;
         mem_byteenable = s0_byteenable;
         mem_chipselect = 1'b1;
         mem_write      = s0_write;
         mem_writedata  = s0_writedata;
      end else if (grant1_s) begin
         // an increment starts as a plain read of the target word
         mem_address    = s1_address;
         mem_chipselect = 1'b1;
         mem_write      = s1_write;
         mem_writedata  = s1_writedata;
      end else if (wb_s) begin
         mem_address    = incr_addr_r;
         mem_chipselect = 1'b1;
         mem_write      = 1'b1;
         mem_writedata  = wb_data_s;
      end else begin
         mem_chipselect = 1'b0;
      end
   end

   // Sequencer FSM, round-robin pointer and registered return strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         last_r      <= 1'b1;
         rdv0_r      <= 1'b0;
         rdv1_r      <= 1'b0;
         sat_r       <= 1'b0;
         incr_addr_r <= {ADDR_W{1'b0}};
         incr_add_r  <= {DATA_W{1'b0}};
      end else begin
         rdv0_r <= grant0_s && s0_read;
         rdv1_r <= grant1_s && s1_read;
         sat_r  <= wb_s && ovf_s && SATURATE;
         case (state_r)
            ST_IDLE: begin
               if (grant0_s) begin
                  last_r <= 1'b0;
               end else if (grant1_s) begin
                  last_r <= 1'b1;
               end
               if (grant1_s && s1_incr) begin
                  state_r     <= ST_INCR_WB;
                  incr_addr_r <= s1_address;
                  incr_add_r  <= s1_writedata;
               end
            end
            ST_INCR_WB: state_r <= ST_IDLE;
            default:    state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter
//    Directed bench for onchip_mem_arbiter. Two instances share the same
//    stimulus: u_dut (clamping increments) and u_dut_w (wrapping increments),
//    each with its own RAM model. Read data is checked against a reference
//    memory through per-port scoreboard queues.
module tb_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  s0_address;
   logic [3:0]  s0_byteenable;
   logic        s0_read, s0_write;
   logic [31:0] s0_writedata;
   logic [4:0]  s1_address;
   logic        s1_read, s1_write, s1_incr;
   logic [31:0] s1_writedata;

   logic        s0_waitrequest, s0_readdatavalid, s1_waitrequest, s1_readdatavalid, sat_event;
   logic [31:0] s0_readdata, s1_readdata;
   logic [4:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata, mem_q;

   logic        s0_waitrequest_b, s0_readdatavalid_b, s1_waitrequest_b, s1_readdatavalid_b, sat_event_b;
   logic [31:0] s0_readdata_b, s1_readdata_b;
   logic [4:0]  mem_address_b;
   logic [3:0]  mem_byteenable_b;
   logic        mem_chipselect_b, mem_write_b, mem_clken_b;
   logic [31:0] mem_writedata_b, mem_q_b;

   logic [31:0] mem_a [0:31];
   logic [31:0] mem_b [0:31];

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(5), .DATA_W(32), .SATURATE(1'b1)) u_dut (
      .clk(clk), .reset(reset),
      .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
      .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
      .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
      .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write), .s1_incr(s1_incr),
      .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
      .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
      .sat_event(sat_event),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_q)
   );

   onchip_mem_arbiter #(.ADDR_W(5), .DATA_W(32), .SATURATE(1'b0)) u_dut_w (
      .clk(clk), .reset(reset),
      .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
      .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest_b),
      .s0_readdata(s0_readdata_b), .s0_readdatavalid(s0_readdatavalid_b),
      .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write), .s1_incr(s1_incr),
      .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest_b),
      .s1_readdata(s1_readdata_b), .s1_readdatavalid(s1_readdatavalid_b),
      .sat_event(sat_event_b),
      .mem_address(mem_address_b), .mem_byteenable(mem_byteenable_b),
      .mem_chipselect(mem_chipselect_b), .mem_write(mem_write_b),
      .mem_writedata(mem_writedata_b), .mem_clken(mem_clken_b), .mem_readdata(mem_q_b)
   );

   // RAM model for the clamping instance: registered q, byte-lane writes.
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            for (int i = 0; i < 4; i++)
               if (mem_byteenable[i]) mem_a[mem_address][i*8 +: 8] <= mem_writedata[i*8 +: 8];
         end else begin
            mem_q <= mem_a[mem_address];
         end
      end
   end

   // RAM model for the wrapping instance.
   always @(posedge clk) begin
      if (mem_chipselect_b && mem_clken_b) begin
         if (mem_write_b) begin
            for (int i = 0; i < 4; i++)
               if (mem_byteenable_b[i]) mem_b[mem_address_b][i*8 +: 8] <= mem_writedata_b[i*8 +: 8];
         end else begin
            mem_q_b <= mem_b[mem_address_b];
         end
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ref_mem [0:31];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   int          grant_log [$];
   logic        exp_rdv0 = 1'b0, exp_rdv1 = 1'b0, exp_sat = 1'b0;
   logic        pend = 1'b0;
   logic [4:0]  pend_addr;
   logic [31:0] pend_add;
   logic        acc0, acc1, w0_obs, w1_obs;
   logic [31:0] last_rd0, last_rd1;
   int          cnt_rdv0, cnt_rdv1, cnt_sat;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs at the falling edge, update the model, advance.
   task automatic step();
      logic [32:0] sum;
      logic        sat_n;
      logic [31:0] e;
      @(negedge clk);
      chk1("rdv0", s0_readdatavalid, exp_rdv0);
      if (s0_readdatavalid === 1'b1) begin
         cnt_rdv0++;
         e = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
         chk32("rd0", s0_readdata, e);
         last_rd0 = s0_readdata;
      end
      chk1("rdv1", s1_readdatavalid, exp_rdv1);
      if (s1_readdatavalid === 1'b1) begin
         cnt_rdv1++;
         e = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
         chk32("rd1", s1_readdata, e);
         last_rd1 = s1_readdata;
      end
      chk1("sat", sat_event, exp_sat);
      if (sat_event === 1'b1) cnt_sat++;
      chk1("sat_wrap", sat_event_b, 1'b0);
      if (reset) begin
         chk1("rst_wait0", s0_waitrequest, 1'b1);
         chk1("rst_wait1", s1_waitrequest, 1'b1);
         chk1("rst_cs", mem_chipselect, 1'b0);
         chk1("rst_wr", mem_write, 1'b0);
      end
      // increment write-back happens in the cycle after acceptance unless reset aborts it
      sat_n = 1'b0;
      if (pend && !reset) begin
         sum = {1'b0, ref_mem[pend_addr]} + {1'b0, pend_add};
         ref_mem[pend_addr] = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
         sat_n = sum[32];
      end
      exp_sat = sat_n;
      pend = 1'b0;
      w0_obs = s0_waitrequest;
      w1_obs = s1_waitrequest;
      acc0 = !reset && (s0_read || s0_write) && (s0_waitrequest === 1'b0);
      acc1 = !reset && (s1_read || s1_write || s1_incr) && (s1_waitrequest === 1'b0);
      exp_rdv0 = acc0 && s0_read;
      exp_rdv1 = acc1 && s1_read;
      if (acc0) begin
         grant_log.push_back(0);
         if (s0_read) q0.push_back(ref_mem[s0_address]);
         if (s0_write)
            for (int i = 0; i < 4; i++)
               if (s0_byteenable[i]) ref_mem[s0_address][i*8 +: 8] = s0_writedata[i*8 +: 8];
      end
      if (acc1) begin
         grant_log.push_back(1);
         if (s1_read)  q1.push_back(ref_mem[s1_address]);
         if (s1_write) ref_mem[s1_address] = s1_writedata;
         if (s1_incr) begin
            pend = 1'b1;
            pend_addr = s1_address;
            pend_add = s1_writedata;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc0();
      for (int k = 0; k < 20; k++) begin
         step();
         if (acc0) break;
      end
      if (!acc0) chk1("acc0_timeout", acc0, 1'b1);
   endtask

   task automatic wait_acc1();
      for (int k = 0; k < 20; k++) begin
         step();
         if (acc1) break;
      end
      if (!acc1) chk1("acc1_timeout", acc1, 1'b1);
   endtask

   task automatic p0_wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
      s0_address = a; s0_byteenable = be; s0_writedata = d; s0_write = 1'b1;
      wait_acc0();
      s0_write = 1'b0;
   endtask

   task automatic p0_rd(input logic [4:0] a);
      s0_address = a; s0_read = 1'b1;
      wait_acc0();
      s0_read = 1'b0;
      step();
   endtask

   task automatic p1_inc(input logic [4:0] a, input logic [31:0] add);
      s1_address = a; s1_writedata = add; s1_incr = 1'b1;
      wait_acc1();
      s1_incr = 1'b0;
      step();
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      s0_address = 5'd0; s0_byteenable = 4'hF; s0_read = 1'b0; s0_write = 1'b0; s0_writedata = 32'd0;
      s1_address = 5'd0; s1_read = 1'b0; s1_write = 1'b0; s1_incr = 1'b0; s1_writedata = 32'd0;
      last_rd0 = 32'd0; last_rd1 = 32'd0; cnt_rdv0 = 0; cnt_rdv1 = 0; cnt_sat = 0;
      @(posedge clk); #1;
      step(); step();
      chk1("clken", mem_clken, 1'b1);
      reset = 1'b0;

      // write then read back a full word
      p0_wr(5'd3, 4'hF, 32'hDEAD_BEEF);
      p0_rd(5'd3);
      chk32("tp1_data", last_rd0, 32'hDEAD_BEEF);

      // partial byte-lane write over a known word
      p0_wr(5'd7, 4'hF, 32'hAAAA_AAAA);
      p0_wr(5'd7, 4'b0101, 32'h1122_3344);
      p0_rd(5'd7);
      chk32("tp2_data", last_rd0, 32'hAA22_AA44);

      // both ports hold reads from reset: grants must alternate starting with port 0
      reset = 1'b1; step(); step(); reset = 1'b0;
      grant_log.delete(); cnt_rdv0 = 0; cnt_rdv1 = 0;
      s0_address = 5'd3; s0_read = 1'b1;
      s1_address = 5'd7; s1_read = 1'b1;
      repeat (6) step();
      s0_read = 1'b0; s1_read = 1'b0;
      step();
      chk32("alt_count", grant_log.size(), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < grant_log.size()) chk32($sformatf("alt_grant%0d", i), grant_log[i], i % 2);
      chk32("alt_rdv0", cnt_rdv0, 32'd3);
      chk32("alt_rdv1", cnt_rdv1, 32'd3);
      chk32("alt_last1", last_rd1, 32'hAA22_AA44);

      // overflowing increment: clamp in one instance, wrap in the other
      p0_wr(5'd9, 4'hF, 32'hFFFF_FFF0);
      cnt_sat = 0;
      p1_inc(5'd9, 32'h0000_0020);
      step();
      chk32("sat_count", cnt_sat, 32'd1);
      p0_rd(5'd9);
      chk32("sat_data", last_rd0, 32'hFFFF_FFFF);
      chk32("wrap_data", mem_b[9], 32'h0000_0010);

      // increment blocks a concurrent port 0 read for two cycles
      s1_address = 5'd3; s1_writedata = 32'd1; s1_incr = 1'b1;
      s0_address = 5'd3; s0_read = 1'b1;
      step();
      chk1("blk_acc1", acc1, 1'b1);
      chk1("blk_wait0_t0", w0_obs, 1'b1);
      s1_incr = 1'b0;
      step();
      chk1("blk_wait0_t1", w0_obs, 1'b1);
      chk1("blk_wait1_t1", w1_obs, 1'b1);
      step();
      chk1("blk_acc0_t2", acc0, 1'b1);
      s0_read = 1'b0;
      step();
      chk32("blk_data", last_rd0, 32'hDEAD_BEF0);

      // reset during write-back aborts the increment
      p0_wr(5'd5, 4'hF, 32'h0000_0100);
      s1_address = 5'd5; s1_writedata = 32'd1; s1_incr = 1'b1;
      wait_acc1();
      s1_incr = 1'b0;
      reset = 1'b1;
      step();
      step();
      chk1("abort_rdv0", s0_readdatavalid, 1'b0);
      chk1("abort_rdv1", s1_readdatavalid, 1'b0);
      chk1("abort_sat", sat_event, 1'b0);
      reset = 1'b0;
      p0_rd(5'd5);
      chk32("abort_data", last_rd0, 32'h0000_0100);
      chk32("q0_empty", q0.size(), 32'd0);
      chk32("q1_empty", q1.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port arbiter and sequencer for the 32×32 single-port on-chip RAM that holds the packet analyzer's statistics table. Port 0 serves the Nios II data master for ordinary reads and writes. Port 1 serves the packet-stats engine, which also issues atomic read-modify-write increments. The block drives the RAM's Avalon slave pins and enforces one access per cycle with round-robin fairness.

## Interface
- ADDR_W, 5, word address width; matches RAM depth 32.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- SATURATE, 1, increment behaviour: 1 clamps at all-ones; 0 wraps modulo 2^DATA_W.

Ports:
- clk  in  1  single clock for the block and the RAM.
- reset  in  1  synchronous, active-high.
- s0_address  in  ADDR_W  port 0 word address.
- s0_byteenable  in  DATA_W/8  port 0 byte lanes.
- s0_read, s0_write  in  1  port 0 requests; never asserted together.
- s0_writedata  in  DATA_W  port 0 write data.
- s0_waitrequest  out  1  request not accepted this cycle.
- s0_readdata  out  DATA_W  read data; valid only while s0_readdatavalid is high.
- s0_readdatavalid  out  1  one-cycle read-return strobe.
- s1_address  in  ADDR_W  port 1 word address.
- s1_read, s1_write, s1_incr  in  1  port 1 requests; at most one asserted.
- s1_writedata  in  DATA_W  write data, or increment addend.
- s1_waitrequest, s1_readdata, s1_readdatavalid  out  1/DATA_W/1  same semantics as port 0.
- sat_event  out  1  one-cycle pulse when an increment saturates.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_chipselect, mem_write  out  1  RAM access and write strobes.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  constant 1.
- mem_readdata  in  DATA_W  RAM q; valid in the cycle after a read is issued.

## Operation
- Avalon handshake:
  - A request is accepted in the cycle where it is asserted and its waitrequest is low.
  - Requesters hold the command and all fields stable while waitrequest is high.
- FSM states:
  - IDLE: the RAM is free. A winner is chosen combinationally from the current requests. The winner's command drives the mem_* pins in the same cycle, and its waitrequest is low. The loser's waitrequest is high.
  - INCR_WB: write-back cycle of an increment. Both waitrequests are high.
- Arbitration:
  - A single requester always wins.
  - If both request, the port not granted most recently wins.
  - The last-granted pointer updates on every acceptance.
  - At reset the pointer is set to port 1, so port 0 wins the first tie.
- Port 1 byteenable is fixed at all-ones.
- Read accepted at cycle T:
  - The RAM read is issued in T.
  - At T+1 the requesting port's readdatavalid is registered high for exactly one cycle.
  - Its readdata is passed through from mem_readdata.
- Write accepted at T: the RAM write occurs in T. No return strobe.
- s1_incr accepted at T:
  - In T, a RAM read is issued; address and addend are latched; the FSM moves to INCR_WB.
  - In T+1, compute sum = mem_readdata + addend at DATA_W+1 bits. Write it back to the latched address with mem_write=1 and all byteenables.
  - If sum overflows and SATURATE=1, write all-ones instead and register sat_event high at T+2. If SATURATE=0, write the low DATA_W bits and keep sat_event low.
  - The FSM returns to IDLE at T+2. No readdatavalid is produced.
- Idle cycles drive mem_chipselect=0 and mem_write=0.

## Timing
- Reset values: state IDLE; pointer = port 1; both readdatavalid = 0; sat_event = 0.
- While reset is high, both waitrequests are 1 and mem_chipselect/mem_write are 0. Nothing is accepted.
- Reset in INCR_WB aborts the write-back. The RAM location keeps its pre-increment value. No sat_event is produced.
- Throughput:
  - One read or write per cycle.
  - An increment occupies the RAM for 2 cycles.
  - Back-to-back increments from port 1 sustain one increment per 2 cycles.
- Read latency is 1 cycle from acceptance to readdatavalid, for both ports.
- Both ports requesting continuously alternate grants: 0, 1, 0, 1, and so on. An increment grant counts as one grant.
- If port 0 requests during INCR_WB, it is granted in the following IDLE cycle.
- A read accepted in the cycle after a write to the same address returns the new data. No forwarding logic is required, because the RAM is single-port and sequential.

## Test plan
- Port 0 writes 0xDEADBEEF to address 3 with byteenable 4'hF, then reads address 3. Required: readdatavalid one cycle after read acceptance, with data 0xDEADBEEF.
- Port 0 writes 0x11223344 to address 7 with byteenable 4'b0101 over a stored 0xAAAAAAAA, then reads it back. Required: read returns 0xAA22AA44.
- Both ports hold reads for 6 cycles starting from reset. Required: grants alternate 0,1,0,1,0,1, and each port sees 3 readdatavalid strobes.
- Address 9 holds 0xFFFFFFF0. Port 1 issues s1_incr with addend 0x20. Required with SATURATE=1: memory becomes 0xFFFFFFFF and sat_event pulses once at T+2. Required with SATURATE=0: memory becomes 0x00000010 and no sat_event.
- Port 1 issues an increment at T while port 0 holds a read. Required: port 0 has waitrequest high at T and T+1, and is accepted at T+2.
- Address 5 holds 0x100. Port 1 issues an increment of 1, and reset is asserted at T+1. Required: address 5 still reads 0x100 after reset, and all outputs are at their reset values.
